// File: rtl/calculate_voltage_node_select_pkg.sv
// Shared encodings and default grid constants for the calculateVoltage
// controller and its node-select datapath.
package calc_voltage_pkg;

   localparam int DEF_GRID_W     = 16;
   localparam int DEF_GRID_H     = 12;
   localparam int DEF_MAX_SWEEPS = 256;

   typedef enum logic [1:0] {
      NODE_UNUSED = 2'b00,
      NODE_FREE   = 2'b01,
      NODE_SOURCE = 2'b10,
      NODE_GROUND = 2'b11
   } node_type_e;

   typedef enum logic [2:0] {
      CTRL_IDLE        = 3'd0,
      CTRL_CHOOSE_NODE = 3'd1,
      CTRL_CHECK_NODE  = 3'd2,
      CTRL_SOLVE_NODE  = 3'd3,
      CTRL_DONE        = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/calculate_voltage_node_select_go_edge_detect.sv
// Rising-edge detector for a controller go level: rise is high in the
// cycle go is high and was low in the previous cycle.
module go_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic go,
   output logic rise
);

   logic go_d, go_q;

   always_comb go_d = go;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) go_q <= 1'b0;
      else     go_q <= go_d;
   end

   assign rise = go & ~go_q;

endmodule

// File: rtl/calculate_voltage_node_select.sv
// Node selection / validation datapath for the calculateVoltage solver.
// Define CHECKERBOARD_EN for red-black sweep order; default is raster order.
module calculate_voltage_node_select
   import calc_voltage_pkg::*;
#(
   parameter int GRID_W     = DEF_GRID_W,
   parameter int GRID_H     = DEF_GRID_H,
   parameter int ADDR_W     = 8,
   parameter int MAX_SWEEPS = DEF_MAX_SWEEPS,
   parameter int SWEEP_W    = 9
) (
   input  logic                       clk,
   input  logic                       program_reset,
   input  logic                       go_choose_node,
   input  logic                       go_check_node,
   input  logic                       node_updated,
   output logic [ADDR_W-1:0]          type_rd_addr,
   input  logic [1:0]                 type_rd_data,
   output logic                       node_chosen,
   output logic                       all_done,
   output logic                       node_checked,
   output logic                       node_valid,
   output logic [$clog2(GRID_W)-1:0]  node_x,
   output logic [$clog2(GRID_H)-1:0]  node_y,
   output logic [ADDR_W-1:0]          node_addr,
   output logic [SWEEP_W-1:0]         sweep_count,
   output logic                       converged
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);

   logic choose_rise, check_rise, choose_go, check_go;
   logic [XW-1:0] node_x_d, node_x_q, adv_x;
   logic [YW-1:0] node_y_d, node_y_q, adv_y;
   logic [SWEEP_W-1:0] sweep_count_d, sweep_count_q;
   logic first_pending_d, first_pending_q, dirty_d, dirty_q;
   logic all_done_d, all_done_q, converged_d, converged_q;
   logic node_chosen_d, node_chosen_q, rd_pend_d, rd_pend_q;
   logic node_checked_d, node_checked_q, node_valid_d, node_valid_q;
   logic sweep_last;

   go_edge_detect u_choose_edge (.clk(clk), .rst(program_reset), .go(go_choose_node), .rise(choose_rise));
   go_edge_detect u_check_edge  (.clk(clk), .rst(program_reset), .go(go_check_node),  .rise(check_rise));

   // Choose beats a coincident check; nothing is accepted once the solve is over.
   assign choose_go = choose_rise & ~all_done_q;
   assign check_go  = check_rise & ~choose_rise & ~all_done_q;

`ifdef CHECKERBOARD_EN
   logic pass_d, pass_q, adv_pass;
   logic [YW-1:0] next_row;

   // Within a pass, step two columns; on a new row start at the column whose parity matches the pass.
   always_comb begin
      adv_x      = node_x_q;
      adv_y      = node_y_q;
      adv_pass   = pass_q;
      sweep_last = 1'b0;
      next_row   = node_y_q + YW'(1);
      if (int'(node_x_q) + 2 < GRID_W) begin
         adv_x = node_x_q + XW'(2);
      end else if (int'(node_y_q) + 1 < GRID_H) begin
         adv_y = next_row;
         adv_x = XW'(pass_q ^ next_row[0]);
      end else if (!pass_q) begin
         adv_pass = 1'b1;
         adv_y    = '0;
         adv_x    = XW'(1);
      end else begin
         sweep_last = 1'b1;
      end
   end

   always_comb begin
      pass_d = pass_q;
      if (choose_go) pass_d = (first_pending_q || sweep_last) ? 1'b0 : adv_pass;
   end

   always_ff @(posedge clk or posedge program_reset) begin
      if (program_reset) pass_q <= 1'b0;
      else               pass_q <= pass_d;
   end
`else
   always_comb begin
      adv_x      = node_x_q + XW'(1);
      adv_y      = node_y_q;
      sweep_last = 1'b0;
      if (node_x_q == XW'(GRID_W - 1)) begin
         adv_x = '0;
         adv_y = node_y_q + YW'(1);
         sweep_last = (node_y_q == YW'(GRID_H - 1));
      end
   end
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      node_x_d        = node_x_q;
      node_y_d        = node_y_q;
      first_pending_d = first_pending_q;
      dirty_d         = dirty_q | node_updated;
      sweep_count_d   = sweep_count_q;
      all_done_d      = all_done_q;
      converged_d     = converged_q;
      node_chosen_d   = 1'b0;
      if (choose_go) begin
         if (first_pending_q) begin
            node_x_d        = '0;
            node_y_d        = '0;
            first_pending_d = 1'b0;
            node_chosen_d   = 1'b1;
         end else if (!sweep_last) begin
            node_x_d      = adv_x;
            node_y_d      = adv_y;
            node_chosen_d = 1'b1;
         end else begin
            sweep_count_d = sweep_count_q + SWEEP_W'(1);
            if (!(dirty_q | node_updated)) begin
               all_done_d  = 1'b1;
               converged_d = 1'b1;
            end else if (sweep_count_d == SWEEP_W'(MAX_SWEEPS)) begin
               all_done_d = 1'b1;
            end else begin
               node_x_d      = '0;
               node_y_d      = '0;
               dirty_d       = 1'b0;
               node_chosen_d = 1'b1;
            end
         end
      end
   end

   // The RAM answers one cycle after the address; capture it in the cycle after the check request.
   always_comb begin
      rd_pend_d      = check_go;
      node_checked_d = rd_pend_q;
      node_valid_d   = node_valid_q;
      if (rd_pend_q) node_valid_d = (type_rd_data == NODE_FREE);
   end

   always_ff @(posedge clk or posedge program_reset) begin
      if (program_reset) begin
         node_x_q        <= '0;
         node_y_q        <= '0;
         first_pending_q <= 1'b1;
         dirty_q         <= 1'b0;
         sweep_count_q   <= '0;
         all_done_q      <= 1'b0;
         converged_q     <= 1'b0;
         node_chosen_q   <= 1'b0;
         rd_pend_q       <= 1'b0;
         node_checked_q  <= 1'b0;
         node_valid_q    <= 1'b0;
      end else begin
         node_x_q        <= node_x_d;
         node_y_q        <= node_y_d;
         first_pending_q <= first_pending_d;
         dirty_q         <= dirty_d;
         sweep_count_q   <= sweep_count_d;
         all_done_q      <= all_done_d;
         converged_q     <= converged_d;
         node_chosen_q   <= node_chosen_d;
         rd_pend_q       <= rd_pend_d;
         node_checked_q  <= node_checked_d;
         node_valid_q    <= node_valid_d;
      end
   end

   assign node_x       = node_x_q;
   assign node_y       = node_y_q;
   assign node_addr    = ADDR_W'(node_y_q) * ADDR_W'(GRID_W) + ADDR_W'(node_x_q);
   assign type_rd_addr = node_addr;
   assign node_chosen  = node_chosen_q;
   assign all_done     = all_done_q;
   assign converged    = converged_q;
   assign sweep_count  = sweep_count_q;
   assign node_checked = node_checked_q;
   assign node_valid   = node_valid_q;

endmodule

// File: tb/tb_calculate_voltage_node_select.sv
// Directed bench on a 2x2 grid with a 3-sweep limit and a behavioural node-type RAM.
module tb_calculate_voltage_node_select;
   import calc_voltage_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       program_reset, go_choose_node, go_check_node, node_updated;
   logic [1:0] type_rd_addr, type_rd_data, node_addr;
   logic       node_chosen, all_done, node_checked, node_valid, converged;
   logic [0:0] node_x, node_y;
   logic [8:0] sweep_count;

   logic [1:0] ram [4];
   always @(posedge clk) type_rd_data <= ram[type_rd_addr];

   calculate_voltage_node_select #(
      .GRID_W(2), .GRID_H(2), .ADDR_W(2), .MAX_SWEEPS(3), .SWEEP_W(9)
   ) dut (
      .clk(clk), .program_reset(program_reset),
      .go_choose_node(go_choose_node), .go_check_node(go_check_node),
      .node_updated(node_updated), .type_rd_addr(type_rd_addr),
      .type_rd_data(type_rd_data), .node_chosen(node_chosen),
      .all_done(all_done), .node_checked(node_checked), .node_valid(node_valid),
      .node_x(node_x), .node_y(node_y), .node_addr(node_addr),
      .sweep_count(sweep_count), .converged(converged)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [0:0] x;
      logic [0:0] y;
      logic [1:0] addr;
      logic       valid;
   } vec_t;

   vec_t vecs [4];

   logic       s_chosen, s_done, s_conv, s_early, s_checked, s_valid;
   logic [0:0] s_x, s_y;
   logic [1:0] s_addr;
   logic [8:0] s_sweep;

   task automatic apply_reset();
      program_reset  = 1'b1;
      go_choose_node = 1'b0;
      go_check_node  = 1'b0;
      node_updated   = 1'b0;
      repeat (2) @(negedge clk);
      program_reset = 1'b0;
      @(negedge clk);
   endtask

   // Raise choose for one cycle, sample results the cycle after, then leave one low cycle.
   task automatic do_choose(input logic upd);
      go_choose_node = 1'b1;
      node_updated   = upd;
      @(negedge clk);
      s_chosen = node_chosen;
      s_done   = all_done;
      s_conv   = converged;
      s_x      = node_x;
      s_y      = node_y;
      s_addr   = node_addr;
      s_sweep  = sweep_count;
      go_choose_node = 1'b0;
      node_updated   = 1'b0;
      @(negedge clk);
   endtask

   // Check request dropped after one cycle; the read must still complete at edge+2.
   task automatic do_check();
      go_check_node = 1'b1;
      @(negedge clk);
      s_early = node_checked;
      go_check_node = 1'b0;
      @(negedge clk);
      s_checked = node_checked;
      s_valid   = node_valid;
   endtask

   initial begin
      int pulses;
      ram[0] = NODE_FREE;
      ram[1] = NODE_SOURCE;
      ram[2] = NODE_FREE;
      ram[3] = NODE_GROUND;
`ifdef CHECKERBOARD_EN
      vecs[0] = '{x: 1'b0, y: 1'b0, addr: 2'd0, valid: 1'b1};
      vecs[1] = '{x: 1'b1, y: 1'b1, addr: 2'd3, valid: 1'b0};
      vecs[2] = '{x: 1'b1, y: 1'b0, addr: 2'd1, valid: 1'b0};
      vecs[3] = '{x: 1'b0, y: 1'b1, addr: 2'd2, valid: 1'b1};
`else
      vecs[0] = '{x: 1'b0, y: 1'b0, addr: 2'd0, valid: 1'b1};
      vecs[1] = '{x: 1'b1, y: 1'b0, addr: 2'd1, valid: 1'b0};
      vecs[2] = '{x: 1'b0, y: 1'b1, addr: 2'd2, valid: 1'b1};
      vecs[3] = '{x: 1'b1, y: 1'b1, addr: 2'd3, valid: 1'b0};
`endif

      // Reset values, sampled while reset is held.
      program_reset  = 1'b1;
      go_choose_node = 1'b0;
      go_check_node  = 1'b0;
      node_updated   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_chosen",   node_chosen,  0);
      check("rst_done",     all_done,     0);
      check("rst_checked",  node_checked, 0);
      check("rst_valid",    node_valid,   0);
      check("rst_xy",       {node_x, node_y}, 0);
      check("rst_addr",     node_addr,    0);
      check("rst_rd_addr",  type_rd_addr, 0);
      check("rst_sweep",    sweep_count,  0);
      check("rst_conv",     converged,    0);
      program_reset = 1'b0;
      @(negedge clk);

      // One full sweep: choose then check each node in visiting order.
      for (int i = 0; i < 4; i++) begin
         do_choose(1'b0);
         check($sformatf("v%0d_chosen", i), s_chosen, 1);
         check($sformatf("v%0d_x", i),      s_x,      vecs[i].x);
         check($sformatf("v%0d_y", i),      s_y,      vecs[i].y);
         check($sformatf("v%0d_addr", i),   s_addr,   vecs[i].addr);
         check($sformatf("v%0d_rd_addr", i), type_rd_addr, vecs[i].addr);
         do_check();
         check($sformatf("v%0d_early", i),   s_early,   0);
         check($sformatf("v%0d_checked", i), s_checked, 1);
         check($sformatf("v%0d_valid", i),   s_valid,   vecs[i].valid);
      end

      // End of a clean sweep converges.
      do_choose(1'b0);
      check("conv_chosen", s_chosen, 0);
      check("conv_done",   s_done,   1);
      check("conv_conv",   s_conv,   1);
      check("conv_sweep",  s_sweep,  1);
      do_choose(1'b0);
      check("sticky_chosen", s_chosen, 0);
      check("sticky_done",   s_done,   1);
      check("sticky_addr",   s_addr,   vecs[3].addr);
      do_check();
      check("done_check_ignored", s_checked, 0);

      // Updates keep the solve going until the sweep limit.
      apply_reset();
      for (int i = 0; i < 4; i++) do_choose(1'b0);
      do_choose(1'b1);
      check("late_upd_chosen", s_chosen, 1);
      check("late_upd_addr",   s_addr,   0);
      check("late_upd_done",   s_done,   0);
      check("late_upd_sweep",  s_sweep,  1);
      node_updated = 1'b1;
      @(negedge clk);
      node_updated = 1'b0;
      for (int i = 0; i < 3; i++) do_choose(1'b0);
      do_choose(1'b0);
      check("dirty_chosen", s_chosen, 1);
      check("dirty_done",   s_done,   0);
      check("dirty_sweep",  s_sweep,  2);
      for (int i = 0; i < 3; i++) do_choose(1'b0);
      do_choose(1'b1);
      check("limit_chosen", s_chosen, 0);
      check("limit_done",   s_done,   1);
      check("limit_conv",   s_conv,   0);
      check("limit_sweep",  s_sweep,  3);

      // A held choose level selects exactly one node.
      apply_reset();
      pulses = 0;
      go_choose_node = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (node_chosen) pulses++;
      end
      go_choose_node = 1'b0;
      @(negedge clk);
      check("held_pulses", pulses, 1);

      // Reset during an in-flight check suppresses the pulse.
      go_check_node = 1'b1;
      @(negedge clk);
      go_check_node = 1'b0;
      program_reset = 1'b1;
      @(negedge clk);
      check("rst_mid_checked", node_checked, 0);
      program_reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (node_checked) pulses++;
      end
      check("rst_mid_pulses", pulses, 0);

      // Coincident requests: choose is taken, check is dropped.
      go_choose_node = 1'b1;
      go_check_node  = 1'b1;
      @(negedge clk);
      check("both_chosen",  node_chosen,  1);
      check("both_early",   node_checked, 0);
      go_choose_node = 1'b0;
      go_check_node  = 1'b0;
      @(negedge clk);
      check("both_checked", node_checked, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calculate_voltage_node_select.md
Name: calculate_voltage_node_select

Overview:
- Node-selection/validation datapath directly downstream of the calculateVoltage controller.
- Consumes the controller's go_choose_node / go_check_node strobes.
- Returns the node_chosen, all_done, node_checked and node_valid handshakes that drive the controller's CHOOSE_NODE and CHECK_NODE transitions.
- Walks the solver grid sweep by sweep, reads each node's type from the node-type RAM, and decides convergence (end of solve) from per-sweep update activity.

Parameters:
- GRID_W, 16, grid columns (x range 0..GRID_W-1)
- GRID_H, 12, grid rows (y range 0..GRID_H-1)
- ADDR_W, 8, node-type RAM address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H
- MAX_SWEEPS, 256, hard sweep limit; forces all_done even when not converged
- SWEEP_W, 9, sweep counter width; must satisfy 2^SWEEP_W > MAX_SWEEPS

Ports:
- clk  in  1  system clock
- program_reset  in  1  asynchronous, active-high reset
- go_choose_node  in  1  controller level request: pick next node
- go_check_node  in  1  controller level request: classify current node
- node_updated  in  1  one-cycle strobe from ops datapath: last node voltage moved more than tolerance
- type_rd_addr  out  ADDR_W  node-type RAM read address (synchronous RAM, 1-cycle read latency)
- type_rd_data  in  2  node-type RAM read data
- node_chosen  out  1  one-cycle pulse: new node selected
- all_done  out  1  level: solve finished
- node_checked  out  1  one-cycle pulse: classification ready
- node_valid  out  1  current node is solvable; qualified by node_checked
- node_x  out  log2(GRID_W)  current column
- node_y  out  log2(GRID_H)  current row
- node_addr  out  ADDR_W  current linear address, node_y*GRID_W + node_x
- sweep_count  out  SWEEP_W  completed sweeps
- converged  out  1  all_done reached by convergence, not by the sweep limit

Behaviour:
- Clock and reset: single clock clk; program_reset is asynchronous and active-high.
- Reset values: all outputs 0, type_rd_addr 0, dirty flag 0, first_pending 1.
- Request edge detection: go_* are level signals. A request is acted on only in the cycle the signal rises (go high, previous-cycle go low). Holding go high never re-triggers.
- Choose, on a go_choose_node rising edge in cycle T:
  - first_pending=1 -> select (0,0), clear first_pending.
  - node not last in sweep -> advance: x+1; at x=GRID_W-1, wrap to x=0, y+1.
  - node last in sweep -> end of sweep:
    - sweep_count+1.
    - d = dirty | node_updated(T).
    - If d=0: all_done=1 and converged=1.
    - Else if the new sweep_count equals MAX_SWEEPS: all_done=1, converged=0.
    - Otherwise: select (0,0), clear dirty.
  - node_chosen pulses in T+1 only when a node was selected. all_done is never asserted together with node_chosen.
  - node_x, node_y and node_addr update at T+1 and stay stable until the next choose.
- Dirty flag: set by any node_updated strobe. node_updated arriving in the end-of-sweep cycle counts toward the finishing sweep.
- all_done/converged: sticky until program_reset. Further go strobes are ignored once all_done=1.
- Check, on a go_check_node rising edge in cycle T:
  - type_rd_addr equals node_addr at all times.
  - type_rd_data is sampled at T+1.
  - node_checked pulses at T+2; node_valid is set at T+2 and holds until the next check.
  - Type encoding: 00 UNUSED, 01 FREE, 10 SOURCE, 11 GROUND. node_valid=1 only for FREE.
- Check in flight: completes even if go_check_node drops.
- Simultaneous rising edges on both go strobes (illegal from the controller): choose wins; check is dropped.
- Reset mid-check: the pending read is discarded; no node_checked pulse.

Optional Feature:
- Macro: CHECKERBOARD_EN.
- Defined: red-black ordering. Each sweep has two passes:
  - pass 0 visits nodes with (x+y) even, in raster order;
  - pass 1 visits nodes with (x+y) odd, in raster order.
  - The end of sweep is the last odd node. The convergence/limit rules are unchanged, applied once per full sweep.
- Undefined: plain raster order over all GRID_W*GRID_H nodes; pass logic is absent.

Decomposition:
- Package calc_voltage_pkg:
  - node-type encodings (UNUSED/FREE/SOURCE/GROUND);
  - default GRID_W, GRID_H and MAX_SWEEPS constants;
  - controller state encodings, shared with the controller.
- One sub-module, go_edge_detect: registered rising-edge detector. Instantiated twice, once for go_choose_node and once for go_check_node.

Test Plan:
- Reset, then a go_choose_node rise -> node_chosen pulse 1 cycle later; node_x=0, node_y=0, node_addr=0.
- 2x2 grid, RAM {FREE,SOURCE,FREE,GROUND}, check each node -> node_checked at edge+2 each time; node_valid sequence 1,0,1,0.
- Full sweep with no node_updated -> the 5th choose gives all_done=1, converged=1, sweep_count=1, no node_chosen.
- node_updated strobed in the same cycle as the end-of-sweep choose -> new sweep starts at (0,0); all_done stays 0.
- MAX_SWEEPS=3, node_updated every sweep -> all_done=1, converged=0, sweep_count=3.
- go_choose_node held high for 10 cycles -> exactly one node_chosen. Reset asserted mid-check -> no node_checked pulse.
- CHECKERBOARD_EN with a 2x2 grid -> visit order (0,0), (1,1), (1,0), (0,1).
